pipe_hazard_ctrl: RTL

//  Stall/flush controller producing the write enables and bubble/flush strobes consumed by the

---
 rtl/pipe_hazard_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Stall/flush controller that sits beside the ID stage of the 5-stage pipeline.
//   It produces the write enables and the bubble/flush strobes for the PC, IF/ID
//   and ID/EX pipeline registers. It also counts stall cycles for performance debug.
//   - Load-use hazard: stalls PC and IF/ID for one cycle and injects a bubble into ID/EX.
//   - Mult/div in EX: freezes the front end for MDU_LAT-1 cycles after the issue edge.
//   - Taken branch in EX: flushes IF/ID and bubbles ID/EX (wrong-path squash).
// Parameters
//   MDU_LAT  EX occupancy of a mult/div op in cycles (2..8)
//   CNT_W    width of the MDU countdown; must hold MDU_LAT-1
// Ports
//   clk, clr                      clock, asynchronous active-high reset
//   id_rs, id_rt, id_use_rs/rt    source registers of the ID instruction and their use flags
//   id_mdu_start                  ID instruction is mult/div
//   ex_wreg, ex_m2reg, ex_rd      EX instruction: writes reg file, is a load, destination
//   ex_branch_taken               branch in EX resolved taken
//   pc_we, ifid_we, idex_we       pipeline register write enables
//   idex_bubble, ifid_flush       load NOP into ID/EX / IF/ID this edge
//   mdu_busy                      high while waiting on the MDU
//   stall_cycles                  saturating count of cycles with pc_we == 0
module pipe_hazard_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 3
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_mdu_start,
  input  logic        ex_wreg,
  input  logic        ex_m2reg,
  input  logic [4:0]  ex_rd,
  input  logic        ex_branch_taken,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        idex_we,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic        mdu_busy,
  output logic [31:0] stall_cycles
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  state_t             state, state_next;
  logic   [CNT_W-1:0] cnt, cnt_next;
  logic               load_use;

  assign load_use = ex_m2reg & ex_wreg & (ex_rd != 5'd0) &
                    ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Outputs are forced low while clr is high, so the clr term gates the whole decode.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    idex_we     = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    mdu_busy    = 1'b0;
    if (!clr) begin
      unique case (state)
        RUN: begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
          idex_we = 1'b1;
          if (ex_branch_taken) begin
            // ID holds a wrong-path instruction, so its hazards are irrelevant.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (load_use) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
          end else if (id_mdu_start) begin
            state_next = MDU_WAIT;
            cnt_next   = CNT_W'(MDU_LAT - 2);
          end
        end
        MDU_WAIT: begin
          mdu_busy = 1'b1;
          if (cnt == '0) begin
            state_next = RUN;
          end else begin
            cnt_next = cnt - 1'b1;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stall_cycles <= '0;
    end else if (!pc_we && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule
